// File: rtl/expunit_seq.sv
// Sequencer for one exponential unit: streams a vector of FP16 operands into the unit,
// steps its internal stage register only when the result can advance, and buffers results for the sink.
module expunit_seq #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic [15:0]      exp_a,
  output logic             exp_stage_run,
  input  logic [15:0]      exp_z,
  input  logic [7:0]       exp_status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [7:0]       out_status,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [7:0]       err_flags
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1'b1);

  state_t           r_state;
  state_t           w_next_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_in_cnt;
  logic [LEN_W-1:0] r_out_cnt;
  logic             r_s1_v;
  logic             r_o_v;
  logic [15:0]      r_out_data;
  logic [7:0]       r_out_status;
  logic [7:0]       r_err_flags;

  logic             w_run;
  logic             w_o_free;
  logic             w_s1_adv;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_capture;
  logic             w_start_acc;
  logic [LEN_W-1:0] w_len_m1;
  logic             w_out_is_last;

  // The stage register may only step when its current content (if any) can move into the output register.
  assign w_o_free      = !r_o_v || out_ready;
  assign w_s1_adv      = !r_s1_v || w_o_free;
  assign exp_stage_run = w_run && w_s1_adv;
  assign in_ready      = w_run && w_s1_adv && (r_in_cnt != r_len);
  assign w_in_fire     = in_valid && in_ready;
  assign w_out_fire    = r_o_v && out_ready;
  assign w_capture     = r_s1_v && w_o_free;
  assign w_start_acc   = (r_state == ST_IDLE) && start;
  assign w_len_m1      = r_len - CNT_ONE;
  assign w_out_is_last = (r_out_cnt == w_len_m1);

  assign exp_a      = in_data;
  assign out_valid  = r_o_v;
  assign out_data   = r_out_data;
  assign out_status = r_out_status;
  assign out_last   = r_o_v && w_out_is_last;
  assign err_flags  = r_err_flags;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = (vec_len == CNT_ZERO) ? ST_DONE : ST_RUN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_out_fire && w_out_is_last) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_run = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_run = 1'b1;
        busy  = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        w_run = 1'b0;
      end
    endcase
  end

  // Vector length, element counters and the sticky error summary; err_flags survives until the next start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len       <= CNT_ZERO;
      r_in_cnt    <= CNT_ZERO;
      r_out_cnt   <= CNT_ZERO;
      r_err_flags <= 8'h00;
    end else if (w_start_acc) begin
      r_len       <= vec_len;
      r_in_cnt    <= CNT_ZERO;
      r_out_cnt   <= CNT_ZERO;
      r_err_flags <= 8'h00;
    end else begin
      if (w_in_fire) begin
        r_in_cnt <= r_in_cnt + CNT_ONE;
      end
      if (w_out_fire) begin
        r_out_cnt <= r_out_cnt + CNT_ONE;
      end
      if (w_capture) begin
        r_err_flags <= r_err_flags | exp_status;
      end
    end
  end

  // Bubbles still step the unit's stage register, so s1_v records whether that step carried an element.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_v       <= 1'b0;
      r_o_v        <= 1'b0;
      r_out_data   <= 16'h0000;
      r_out_status <= 8'h00;
    end else begin
      if (exp_stage_run) begin
        r_s1_v <= w_in_fire;
      end
      if (w_capture) begin
        r_out_data   <= exp_z;
        r_out_status <= exp_status;
        r_o_v        <= 1'b1;
      end else if (w_o_free) begin
        r_o_v <= 1'b0;
      end
    end
  end

endmodule
